// File: rtl/sdram_arb_nch.sv
// rtl/sdram_arb_nch.sv - N-channel SDRAM request arbiter/demux with per-channel request latch and read return
// Optional: define SDRAM_ARB_RR_EN for round-robin arbitration (default fixed priority, channel 0 highest).
module sdram_arb_nch #(
   parameter int NCH = 4,
   parameter int AW  = 26,
   parameter int DW  = 64,
   parameter int WW  = 16
) (
   input  logic              CLK,
   input  logic              nRESET,
   input  logic [NCH-1:0]    REQ_STB,
   input  logic [NCH-1:0]    REQ_WR,
   input  logic [NCH-1:0]    REQ_BURST,
   input  logic [NCH*AW-1:0] REQ_ADDR,
   input  logic [NCH*WW-1:0] REQ_WDATA,
   input  logic [NCH*2-1:0]  REQ_BS,
   output logic [NCH*DW-1:0] RD_DATA,
   output logic [NCH-1:0]    DONE,
   output logic [NCH-1:0]    BUSY,
   output logic [NCH-1:0]    OVF,
   output logic              SDRAM_RD,
   output logic              SDRAM_WR,
   output logic              SDRAM_BURST,
   output logic [AW-1:0]     SDRAM_ADDR,
   output logic [WW-1:0]     SDRAM_DIN,
   output logic [1:0]        SDRAM_BS,
   input  logic [DW-1:0]     SDRAM_DOUT,
   input  logic              SDRAM_READY
);
   localparam int CW = $clog2(NCH);

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;
   state_t state_q, state_d;

   logic [NCH-1:0]    pend_q, pend_d, busy_q, busy_d, ovf_q, ovf_d, done_q, done_d;
   logic [NCH-1:0]    lwr_q, lwr_d, lburst_q, lburst_d;
   logic [NCH*AW-1:0] laddr_q, laddr_d;
   logic [NCH*WW-1:0] lwdata_q, lwdata_d;
   logic [NCH*2-1:0]  lbs_q, lbs_d;
   logic [NCH*DW-1:0] rdata_q, rdata_d;
   logic [CW-1:0]     cur_q, cur_d;
   logic              rd_q, rd_d, wr_q, wr_d, burst_q, burst_d;
   logic [AW-1:0]     addr_q, addr_d;
   logic [WW-1:0]     din_q, din_d;
   logic [1:0]        bs_q, bs_d;

   logic              done_fire, found, grant, win_acc;
   logic [NCH-1:0]    accept, cand;
   logic [CW-1:0]     win, idx;
   logic              w_wr, w_burst;
   logic [AW-1:0]     w_addr;
   logic [WW-1:0]     w_wdata;
   logic [1:0]        w_bs;

`ifdef SDRAM_ARB_RR_EN
   logic [CW-1:0]     last_q, last_d, start;
   logic [CW:0]       sum;
`endif

   // A channel finishing this cycle may take a fresh strobe without flagging overflow.
   always_comb begin
      done_fire = (state_q == S_WAIT) && SDRAM_READY;
      for (int i = 0; i < NCH; i++)
         accept[i] = REQ_STB[i] && (!busy_q[i] || (done_fire && (cur_q == CW'(i))));
      cand = pend_q | accept;
   end

   always_comb begin
      win   = '0;
      found = 1'b0;
      idx   = '0;
`ifdef SDRAM_ARB_RR_EN
      start = (last_q == CW'(NCH-1)) ? '0 : last_q + 1'b1;
      sum   = '0;
`endif
      for (int k = 0; k < NCH; k++) begin
`ifdef SDRAM_ARB_RR_EN
         sum = {1'b0, start} + (CW+1)'(k);
         if (sum >= (CW+1)'(NCH))
            sum = sum - (CW+1)'(NCH);
         idx = sum[CW-1:0];
`else
         idx = CW'(k);
`endif
         if (!found && cand[idx]) begin
            found = 1'b1;
            win   = idx;
         end
      end
   end

   // Same-cycle strobes bypass the latch so a grant costs no extra cycle.
   always_comb begin
      win_acc = accept[win];
      w_wr    = win_acc ? REQ_WR[win]              : lwr_q[win];
      w_burst = win_acc ? REQ_BURST[win]           : lburst_q[win];
      w_addr  = win_acc ? REQ_ADDR[win*AW +: AW]   : laddr_q[win*AW +: AW];
      w_wdata = win_acc ? REQ_WDATA[win*WW +: WW]  : lwdata_q[win*WW +: WW];
      w_bs    = win_acc ? REQ_BS[win*2 +: 2]       : lbs_q[win*2 +: 2];
   end

   always_comb begin
      state_d  = state_q;
      pend_d   = pend_q;
      busy_d   = busy_q;
      ovf_d    = ovf_q | (REQ_STB & ~accept);
      done_d   = '0;
      lwr_d    = lwr_q;
      lburst_d = lburst_q;
      laddr_d  = laddr_q;
      lwdata_d = lwdata_q;
      lbs_d    = lbs_q;
      rdata_d  = rdata_q;
      cur_d    = cur_q;
      rd_d     = rd_q;
      wr_d     = wr_q;
      burst_d  = burst_q;
      addr_d   = addr_q;
      din_d    = din_q;
      bs_d     = bs_q;
      grant    = 1'b0;
`ifdef SDRAM_ARB_RR_EN
      last_d   = last_q;
`endif
      for (int i = 0; i < NCH; i++) begin
         if (accept[i]) begin
            pend_d[i]               = 1'b1;
            busy_d[i]               = 1'b1;
            lwr_d[i]                = REQ_WR[i];
            lburst_d[i]             = REQ_BURST[i];
            laddr_d[i*AW +: AW]     = REQ_ADDR[i*AW +: AW];
            lwdata_d[i*WW +: WW]    = REQ_WDATA[i*WW +: WW];
            lbs_d[i*2 +: 2]         = REQ_BS[i*2 +: 2];
         end
      end
      case (state_q)
         S_IDLE: grant = SDRAM_READY && found;
         S_ISSUE: begin
            // READY was high at grant; its fall means the controller took the command.
            if (!SDRAM_READY) begin
               rd_d    = 1'b0;
               wr_d    = 1'b0;
               burst_d = 1'b0;
               state_d = S_WAIT;
            end
         end
         S_WAIT: begin
            if (SDRAM_READY) begin
               if (!lwr_q[cur_q])
                  rdata_d[cur_q*DW +: DW] = SDRAM_DOUT;
               done_d[cur_q] = 1'b1;
               if (!accept[cur_q])
                  busy_d[cur_q] = 1'b0;
               state_d = S_IDLE;
               grant   = found;
            end
         end
         default: state_d = S_IDLE;
      endcase
      if (grant) begin
         pend_d[win] = 1'b0;
         cur_d       = win;
         rd_d        = ~w_wr;
         wr_d        = w_wr;
         burst_d     = w_burst & ~w_wr;
         addr_d      = w_addr;
         din_d       = w_wdata;
         bs_d        = w_bs;
         state_d     = S_ISSUE;
`ifdef SDRAM_ARB_RR_EN
         last_d      = win;
`endif
      end
   end

   always_ff @(posedge CLK) begin
      if (!nRESET) begin
         state_q  <= S_IDLE;
         pend_q   <= '0;
         busy_q   <= '0;
         ovf_q    <= '0;
         done_q   <= '0;
         lwr_q    <= '0;
         lburst_q <= '0;
         laddr_q  <= '0;
         lwdata_q <= '0;
         lbs_q    <= '0;
         rdata_q  <= '0;
         cur_q    <= '0;
         rd_q     <= 1'b0;
         wr_q     <= 1'b0;
         burst_q  <= 1'b0;
         addr_q   <= '0;
         din_q    <= '0;
         bs_q     <= 2'b11;
`ifdef SDRAM_ARB_RR_EN
         last_q   <= CW'(NCH-1);
`endif
      end else begin
         state_q  <= state_d;
         pend_q   <= pend_d;
         busy_q   <= busy_d;
         ovf_q    <= ovf_d;
         done_q   <= done_d;
         lwr_q    <= lwr_d;
         lburst_q <= lburst_d;
         laddr_q  <= laddr_d;
         lwdata_q <= lwdata_d;
         lbs_q    <= lbs_d;
         rdata_q  <= rdata_d;
         cur_q    <= cur_d;
         rd_q     <= rd_d;
         wr_q     <= wr_d;
         burst_q  <= burst_d;
         addr_q   <= addr_d;
         din_q    <= din_d;
         bs_q     <= bs_d;
`ifdef SDRAM_ARB_RR_EN
         last_q   <= last_d;
`endif
      end
   end

   assign RD_DATA     = rdata_q;
   assign DONE        = done_q;
   assign BUSY        = busy_q;
   assign OVF         = ovf_q;
   assign SDRAM_RD    = rd_q;
   assign SDRAM_WR    = wr_q;
   assign SDRAM_BURST = burst_q;
   assign SDRAM_ADDR  = addr_q;
   assign SDRAM_DIN   = din_q;
   assign SDRAM_BS    = bs_q;
endmodule

// File: doc/sdram_arb_nch.md
Name: sdram_arb_nch

Overview:
- Parametrised N-channel SDRAM request arbiter/demux.
- Successor to the fixed 68k/fix/sprite/CD mux in the NeoGeo memory path.
- Each channel posts read or write requests as single-cycle strobes. The block queues one request per channel, arbitrates, drives the single SDRAM controller port, and returns read data per channel with a done pulse.
- Sits between the per-client request generators (68k, LSPC fix/sprite, CD DMA) and the SDRAM controller.

Parameters:
- NCH, 4, number of request channels (2..8); channel 0 has highest fixed priority.
- AW, 26, SDRAM word address width (bits AW:1 of byte address).
- DW, 64, SDRAM read data width (burst word).
- WW, 16, write data width.

Ports:
- CLK  in  1  system clock.
- nRESET  in  1  reset.
- REQ_STB  in  NCH  per-channel request pulse, one cycle.
- REQ_WR  in  NCH  1 = write, 0 = read; sampled with REQ_STB.
- REQ_BURST  in  NCH  1 = burst read (DW bits), 0 = single word; sampled with REQ_STB.
- REQ_ADDR  in  NCH*AW  per-channel address; sampled with REQ_STB.
- REQ_WDATA  in  NCH*WW  per-channel write data; sampled with REQ_STB.
- REQ_BS  in  NCH*2  per-channel byte selects; sampled with REQ_STB.
- RD_DATA  out  NCH*DW  per-channel registered read data.
- DONE  out  NCH  one-cycle completion pulse per channel.
- BUSY  out  NCH  channel has a pending or running request.
- OVF  out  NCH  sticky: a strobe arrived while the channel was BUSY.
- SDRAM_RD  out  1  read command.
- SDRAM_WR  out  1  write command.
- SDRAM_BURST  out  1  burst qualifier.
- SDRAM_ADDR  out  AW  address.
- SDRAM_DIN  out  WW  write data.
- SDRAM_BS  out  2  byte selects.
- SDRAM_DOUT  in  DW  read data; valid when READY rises.
- SDRAM_READY  in  1  controller idle.

Behaviour:
- Clock CLK, reset nRESET, synchronous, active-low.
- Reset values:
  - All outputs 0 except SDRAM_BS = 2'b11.
  - Pending bits, latched requests and OVF cleared. FSM enters IDLE.
  - Reset mid-transfer drops the command at once. No DONE pulse is issued for the aborted channel.
- Request capture:
  - REQ_STB[i] at edge k with channel i idle latches WR/BURST/ADDR/WDATA/BS and sets pending[i].
  - BUSY[i] = 1 after edge k.
  - A strobe while BUSY[i] is ignored (latched copy unchanged) and sets OVF[i]. OVF clears only on reset.
- FSM states:
  - IDLE: if SDRAM_READY and any pending or strobing channel, grant the winner.
    - Winner: lowest index; a same-cycle strobe counts as pending (bypass, zero extra latency).
    - Registered outputs: SDRAM_RD = ~wr, SDRAM_WR = wr, SDRAM_BURST = burst & ~wr. SDRAM_ADDR, SDRAM_DIN and SDRAM_BS come from the winner.
    - Clear pending[winner]. Go to ISSUE.
  - ISSUE: hold command until SDRAM_READY is sampled 1 then 0 (controller accepted). Then drop SDRAM_RD/WR and go to WAIT.
  - WAIT: on SDRAM_READY = 1:
    - For a read, RD_DATA[i] <= SDRAM_DOUT. Single reads place the word in RD_DATA[i][DW-1:DW-16].
    - Pulse DONE[i], clear BUSY[i].
    - Return to IDLE. A back-to-back grant is allowed the same cycle (WAIT→ISSUE directly if another request is pending).
- Latency: strobe at edge k, controller idle → command visible after edge k. DONE equals controller latency + 1 cycle.
- Address/data outputs stay stable from grant until WAIT exits.
- Boundaries:
  - Channel i strobe in the same cycle as its own DONE: accepted as a new request (BUSY re-set, no OVF).
  - All channels pending: served in priority order, one per transaction.
  - NCH = 2: only channels 0–1 exist.

Optional Feature:
- Macro SDRAM_ARB_RR_EN.
- Defined: round-robin arbitration. Search starts at (last granted + 1) mod NCH, so no channel waits more than NCH-1 transactions.
- Undefined: fixed priority, channel 0 highest.

Test Plan:
- Reset: drive nRESET=0 mid-ISSUE → SDRAM_RD=0, BUSY=0, SDRAM_BS=2'b11, no DONE.
- Single read: ch2 strobe with ADDR=26'h0200010, BURST=0; controller returns DOUT=64'hBEEF_0000_0000_0000 → SDRAM_RD high next cycle; RD_DATA[2][63:48]=16'hBEEF; one DONE[2] pulse.
- Simultaneous: ch0 and ch3 strobe in the same cycle → ch0 served first, then ch3. Order of DONE: 0 then 3.
- Overflow: ch1 strobes twice 2 cycles apart while pending → OVF[1]=1, a single DONE[1], first address used.
- Write: ch3 WR=1, WDATA=16'h1234, BS=2'b01 → SDRAM_WR=1, SDRAM_DIN=16'h1234, SDRAM_BS=2'b01, SDRAM_BURST=0.
- RR (SDRAM_ARB_RR_EN defined): ch0 re-strobes on every DONE while ch1 is pending → ch1 granted within 2 transactions. Without the macro, ch1 starves.
